pipelined_adder_tree: RTL and testbench



---
 rtl/pipelined_adder_tree.sv | 193 +++++++++++++++++++
 tb/tb_pipelined_adder_tree.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder_tree.sv
// pipelined_adder_tree
//
// Reduces DIM lanes of WIDTH bits through a registered binary adder tree, then
// accumulates successive tree results into groups framed by in_last. Lanes are
// registered at the input (extended to RES_WIDTH), then pass through L = clog2(DIM)
// registered adder levels and one accumulator register. A non-power-of-two DIM is
// padded with zero lanes. A pending result that is not accepted stalls the pipeline.
//
// Ports:
//   Clock      in   single clock, rising edge
//   Reset      in   synchronous, active-high
//   vector     in   DIM*WIDTH, lane i at [i*WIDTH +: WIDTH]
//   in_valid   in   vector/in_last valid
//   in_last    in   final beat of an accumulation group
//   in_ready   out  beat accepted this cycle when in_valid is also high
//   sum        out  RES_WIDTH group total (wraps modulo 2^RES_WIDTH)
//   overflow   out  group total wrapped at least once
//   finished   out  sum/overflow valid
//   out_ready  in   downstream accepts result
module pipelined_adder_tree #(
  parameter int unsigned DIM      = 2,
  parameter int unsigned WIDTH    = 16,
  parameter bit          SIGNED   = 1'b0,
  parameter int unsigned ACC_BITS = 4,
  localparam int unsigned L         = (DIM > 1) ? $clog2(DIM) : 0,
  localparam int unsigned RES_WIDTH = WIDTH + L + ACC_BITS
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [DIM*WIDTH-1:0]   vector,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [RES_WIDTH-1:0]   sum,
  output logic                   overflow,
  output logic                   finished,
  input  logic                   out_ready
);

  localparam int unsigned P = 1 << L;  // lane count padded to a power of two

  logic stall;
  logic finished_q, finished_d;

  // A result held for the downstream freezes every stage, including the input.
  assign stall    = finished_q && !out_ready;
  assign in_ready = !stall;

  // Lane extension and zero padding.
  logic [RES_WIDTH-1:0] lane_ext [P];

  for (genvar i = 0; i < P; i++) begin : g_lane
    if (i < DIM) begin : g_real
      logic [WIDTH-1:0] lane;
      assign lane = vector[i*WIDTH +: WIDTH];
      if (SIGNED) begin : g_sext
        assign lane_ext[i] = RES_WIDTH'($signed(lane));
      end else begin : g_zext
        assign lane_ext[i] = RES_WIDTH'(lane);
      end
    end else begin : g_pad
      assign lane_ext[i] = '0;
    end
  end

  // Level 0 is the registered input; level k (k >= 1) holds P >> k pair sums.
  logic [RES_WIDTH-1:0] lvl_data [L+1][P];
  logic [L:0]           lvl_valid;
  logic [L:0]           lvl_last;

  for (genvar k = 0; k <= L; k++) begin : g_lvl
    localparam int unsigned N = P >> k;

    logic [RES_WIDTH-1:0] data_d [N];
    logic [RES_WIDTH-1:0] data_q [N];
    logic                 valid_d, valid_q;
    logic                 last_d, last_q;

    if (k == 0) begin : g_in
      assign valid_d = in_valid;
      assign last_d  = in_last;
      for (genvar j = 0; j < N; j++) begin : g_node
        assign data_d[j] = lane_ext[j];
      end
    end else begin : g_add
      assign valid_d = lvl_valid[k-1];
      assign last_d  = lvl_last[k-1];
      for (genvar j = 0; j < N; j++) begin : g_node
        assign data_d[j] = lvl_data[k-1][2*j] + lvl_data[k-1][2*j+1];
      end
    end

    always_ff @(posedge Clock) begin
      if (Reset) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end else if (!stall) begin
        valid_q <= valid_d;
        last_q  <= last_d;
      end
    end

    // Data needs no reset: it is only ever consumed under its valid flag.
    always_ff @(posedge Clock) begin
      if (!stall && valid_d) begin
        data_q <= data_d;
      end
    end

    assign lvl_valid[k] = valid_q;
    assign lvl_last[k]  = last_q;
    for (genvar j = 0; j < P; j++) begin : g_out
      if (j < N) begin : g_used
        assign lvl_data[k][j] = data_q[j];
      end else begin : g_unused
        assign lvl_data[k][j] = '0;
      end
    end
  end

  logic                 t_valid;
  logic                 t_last;
  logic [RES_WIDTH-1:0] t_sum;

  assign t_valid = lvl_valid[L];
  assign t_last  = lvl_last[L];
  assign t_sum   = lvl_data[L][0];

  // Accumulator stage.
  logic [RES_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_acc_q, ovf_acc_d;  // sticky wrap within the open group
  logic [RES_WIDTH-1:0] sum_q, sum_d;
  logic                 overflow_q, overflow_d;
  logic [RES_WIDTH:0]   add_full;
  logic [RES_WIDTH-1:0] add_res;
  logic                 add_ovf;

  always_comb begin
    add_full = {1'b0, acc_q} + {1'b0, t_sum};
    add_res  = add_full[RES_WIDTH-1:0];
    if (SIGNED) begin
      add_ovf = (acc_q[RES_WIDTH-1] == t_sum[RES_WIDTH-1]) &&
                (add_res[RES_WIDTH-1] != acc_q[RES_WIDTH-1]);
    end else begin
      add_ovf = add_full[RES_WIDTH];
    end
  end

  always_comb begin
    acc_d      = acc_q;
    ovf_acc_d  = ovf_acc_q;
    sum_d      = sum_q;
    overflow_d = overflow_q;
    finished_d = finished_q;
    if (!stall) begin
      // Not stalled means any held result is being consumed this cycle.
      finished_d = 1'b0;
      if (t_valid) begin
        if (t_last) begin
          sum_d      = add_res;
          overflow_d = ovf_acc_q | add_ovf;
          finished_d = 1'b1;
          acc_d      = '0;
          ovf_acc_d  = 1'b0;
        end else begin
          acc_d      = add_res;
          ovf_acc_d  = ovf_acc_q | add_ovf;
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      acc_q      <= '0;
      ovf_acc_q  <= 1'b0;
      sum_q      <= '0;
      overflow_q <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      ovf_acc_q  <= ovf_acc_d;
      sum_q      <= sum_d;
      overflow_q <= overflow_d;
      finished_q <= finished_d;
    end
  end

  assign sum      = sum_q;
  assign overflow = overflow_q;
  assign finished = finished_q;

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Bench for pipelined_adder_tree. Three instances:
//   a: defaults (DIM=2, unsigned, RES_WIDTH=21)
//   b: DIM=4, SIGNED=1 (RES_WIDTH=22)
//   c: DIM=2, ACC_BITS=0 (RES_WIDTH=17)
// Expected results are queued when a group's last beat is accepted; one monitor per
// instance pops and compares whenever a result is consumed (finished && out_ready).
module tb_pipelined_adder_tree;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] sum;
    bit          ovf;
    int          cyc;  // -1: latency not checked
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  // Instance a
  logic [31:0] vec_a = '0;
  logic        vld_a = 1'b0, lst_a = 1'b0, rdy_a, ovf_a, fin_a, ordy_a = 1'b1;
  logic [20:0] sum_a;
  // Instance b
  logic [63:0] vec_b = '0;
  logic        vld_b = 1'b0, lst_b = 1'b0, rdy_b, ovf_b, fin_b, ordy_b = 1'b1;
  logic [21:0] sum_b;
  // Instance c
  logic [31:0] vec_c = '0;
  logic        vld_c = 1'b0, lst_c = 1'b0, rdy_c, ovf_c, fin_c, ordy_c = 1'b1;
  logic [16:0] sum_c;

  pipelined_adder_tree u_a (
    .Clock(Clock), .Reset(Reset), .vector(vec_a), .in_valid(vld_a), .in_last(lst_a),
    .in_ready(rdy_a), .sum(sum_a), .overflow(ovf_a), .finished(fin_a), .out_ready(ordy_a)
  );

  pipelined_adder_tree #(.DIM(4), .SIGNED(1'b1)) u_b (
    .Clock(Clock), .Reset(Reset), .vector(vec_b), .in_valid(vld_b), .in_last(lst_b),
    .in_ready(rdy_b), .sum(sum_b), .overflow(ovf_b), .finished(fin_b), .out_ready(ordy_b)
  );

  pipelined_adder_tree #(.DIM(2), .ACC_BITS(0)) u_c (
    .Clock(Clock), .Reset(Reset), .vector(vec_c), .in_valid(vld_c), .in_last(lst_c),
    .in_ready(rdy_c), .sum(sum_c), .overflow(ovf_c), .finished(fin_c), .out_ready(ordy_c)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle();
    vld_a = 1'b0; lst_a = 1'b0;
    vld_b = 1'b0; lst_b = 1'b0;
    vld_c = 1'b0; lst_c = 1'b0;
  endtask

  // Called just after a rising edge. Presents one beat to instance d, waits for it to
  // be accepted and, on a last beat, queues the expected group result.
  task automatic beat(input int d, input logic [63:0] v, input bit last,
                      input logic [31:0] es, input bit eo, input bit lat);
    bit   rdy;
    int   n;
    exp_t e;
    case (d)
      0:       begin vec_a = v[31:0]; vld_a = 1'b1; lst_a = last; end
      1:       begin vec_b = v;       vld_b = 1'b1; lst_b = last; end
      default: begin vec_c = v[31:0]; vld_c = 1'b1; lst_c = last; end
    endcase
    n = 0;
    do begin
      @(negedge Clock);
      rdy = (d == 0) ? rdy_a : (d == 1) ? rdy_b : rdy_c;
      @(posedge Clock);
      #1;
      n++;
    end while (!rdy && n < 50);
    if (!rdy) begin
      chk("beat accept timeout", 32'(rdy), 32'd1);
    end else if (last) begin
      e.sum = es;
      e.ovf = eo;
      // Accepted at the edge just passed; result shows after L+1 further edges.
      e.cyc = lat ? cyc + ((d == 1) ? 3 : 2) : -1;
      case (d)
        0:       q_a.push_back(e);
        1:       q_b.push_back(e);
        default: q_c.push_back(e);
      endcase
    end
  endtask

  // Monitors
  always @(negedge Clock) begin
    if (fin_a && ordy_a) begin
      if (q_a.size() == 0) begin
        chk("a spurious finished", 32'(fin_a), 32'd0);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        chk("a sum", 32'(sum_a), 32'(e.sum[20:0]));
        chk("a overflow", 32'(ovf_a), 32'(e.ovf));
        if (e.cyc >= 0) chk("a latency", cyc, e.cyc);
      end
    end
  end

  always @(negedge Clock) begin
    if (fin_b && ordy_b) begin
      if (q_b.size() == 0) begin
        chk("b spurious finished", 32'(fin_b), 32'd0);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        chk("b sum", 32'(sum_b), 32'(e.sum[21:0]));
        chk("b overflow", 32'(ovf_b), 32'(e.ovf));
        if (e.cyc >= 0) chk("b latency", cyc, e.cyc);
      end
    end
  end

  always @(negedge Clock) begin
    if (fin_c && ordy_c) begin
      if (q_c.size() == 0) begin
        chk("c spurious finished", 32'(fin_c), 32'd0);
      end else begin
        exp_t e;
        e = q_c.pop_front();
        chk("c sum", 32'(sum_c), 32'(e.sum[16:0]));
        chk("c overflow", 32'(ovf_c), 32'(e.ovf));
        if (e.cyc >= 0) chk("c latency", cyc, e.cyc);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge Clock);
    #1 Reset = 1'b0;

    // Reset state
    @(negedge Clock);
    chk("reset finished a", 32'(fin_a), 32'd0);
    chk("reset sum a", 32'(sum_a), 32'd0);
    chk("reset overflow a", 32'(ovf_a), 32'd0);
    chk("reset in_ready a", 32'(rdy_a), 32'd1);
    chk("reset finished b", 32'(fin_b), 32'd0);
    chk("reset sum b", 32'(sum_b), 32'd0);
    chk("reset in_ready c", 32'(rdy_c), 32'd1);
    @(posedge Clock);
    #1;

    // Single-beat group, 2-cycle latency
    beat(0, 64'h0000_0000_0008_0008, 1'b1, 32'd16, 1'b0, 1'b1);
    idle();
    repeat (5) @(posedge Clock);
    #1;

    // Signed DIM=4: {-1,-2,3,5} -> 5, {-8,-8,-8,-8} -> -32
    beat(1, {16'd5, 16'd3, 16'hFFFE, 16'hFFFF}, 1'b1, 32'd5, 1'b0, 1'b1);
    beat(1, {16'hFFF8, 16'hFFF8, 16'hFFF8, 16'hFFF8}, 1'b1, 32'hFFFF_FFE0, 1'b0, 1'b1);
    idle();
    repeat (5) @(posedge Clock);
    #1;

    // Accumulation: {1,2},{3,4},{5,6} -> 21, then {7,7} -> 14 on the next cycle
    beat(0, {16'd2, 16'd1}, 1'b0, 32'd0, 1'b0, 1'b0);
    beat(0, {16'd4, 16'd3}, 1'b0, 32'd0, 1'b0, 1'b0);
    beat(0, {16'd6, 16'd5}, 1'b1, 32'd21, 1'b0, 1'b1);
    beat(0, {16'd7, 16'd7}, 1'b1, 32'd14, 1'b0, 1'b1);
    idle();
    repeat (5) @(posedge Clock);
    #1;

    // ACC_BITS=0 wrap: 0x1FFFE + 0x1FFFE -> 0x1FFFC with overflow; then {1,1} -> 2
    beat(2, {16'hFFFF, 16'hFFFF}, 1'b0, 32'd0, 1'b0, 1'b0);
    beat(2, {16'hFFFF, 16'hFFFF}, 1'b1, 32'h0001_FFFC, 1'b1, 1'b1);
    beat(2, {16'd1, 16'd1}, 1'b1, 32'd2, 1'b0, 1'b1);
    idle();
    repeat (5) @(posedge Clock);
    #1;

    // Backpressure: four single-beat groups while the first result is held
    ordy_a = 1'b0;
    fork
      begin
        beat(0, {16'd1, 16'd1}, 1'b1, 32'd2, 1'b0, 1'b0);
        beat(0, {16'd2, 16'd2}, 1'b1, 32'd4, 1'b0, 1'b0);
        beat(0, {16'd3, 16'd3}, 1'b1, 32'd6, 1'b0, 1'b0);
        beat(0, {16'd4, 16'd4}, 1'b1, 32'd8, 1'b0, 1'b0);
        idle();
      end
      begin
        int n;
        n = 0;
        do begin
          @(negedge Clock);
          n++;
        end while (!fin_a && n < 50);
        chk("bp result pending", 32'(fin_a), 32'd1);
        repeat (4) begin
          @(negedge Clock);
          chk("bp in_ready low", 32'(rdy_a), 32'd0);
          chk("bp sum frozen", 32'(sum_a), 32'd2);
        end
        @(posedge Clock);
        #1 ordy_a = 1'b1;
      end
    join
    repeat (10) @(posedge Clock);
    #1;

    // Reset mid-group: partial group and in-flight beat discarded
    beat(0, {16'd1, 16'd1}, 1'b0, 32'd0, 1'b0, 1'b0);
    vec_a = {16'd2, 16'd2};
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    idle();
    @(negedge Clock);
    chk("in_ready after reset", 32'(rdy_a), 32'd1);
    chk("finished after reset", 32'(fin_a), 32'd0);
    @(posedge Clock);
    #1;
    beat(0, {16'd4, 16'd4}, 1'b1, 32'd8, 1'b0, 1'b1);
    idle();

    repeat (10) @(posedge Clock);
    #1;
    chk("a results outstanding", q_a.size(), 32'd0);
    chk("b results outstanding", q_b.size(), 32'd0);
    chk("c results outstanding", q_c.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
